// File: rtl/masked_randomness_source_pkg.sv
// Shared types and constants for the masked-multiplier randomness source.
// Latency: none (declarations only).
// Backpressure: not applicable.
package masked_randomness_source_pkg;

   // Galois feedback mask for the maximal-length 64-bit polynomial (taps 64, 63, 61, 60)
   localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

   typedef enum logic [1:0] {
      SEED,
      WARMUP,
      RUN
   } rand_src_state_t;

   // Number of pairwise randomness terms an HPC3 multiplier of n shares needs
   function automatic int num_quad(input int n);
      return (n * (n - 1)) / 2;
   endfunction

endpackage

// File: rtl/masked_randomness_source_galois_lfsr_step.sv
// Combinational Galois LFSR unroller: applies STEPS right-shift steps with feedback mask TAPS.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to register the result.
module galois_lfsr_step #(
   parameter int                 WIDTH = 64,
   parameter logic [WIDTH-1:0]   TAPS  = '0,
   parameter int                 STEPS = 1
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] state_o
);

   logic [WIDTH-1:0] s;

   // Chain STEPS single-bit shifts; each shifted-out one folds the tap mask back in
   always_comb begin
      s = state_i;
      for (int i = 0; i < STEPS; i++) begin
         if (s[0]) begin
            s = (s >> 1) ^ TAPS;
         end else begin
            s = s >> 1;
         end
      end
      state_o = s;
   end

endmodule

// File: rtl/masked_randomness_source.sv
// Seeded 64-bit Galois LFSR feeding fresh R/P operands to HPC3 masked multipliers.
// Latency: 2 seed words + WARMUP_CYCLES advances to first valid; fresh output the cycle after each advancing edge.
// Backpressure: in_ready=0 freezes the LFSR in RUN; seed words are only accepted (out_seed_ready) while seeding.
module masked_randomness_source
   import masked_randomness_source_pkg::*;
#(
   parameter int NUM_SHARES    = 2,
   parameter int BIT_WIDTH     = 2,
   parameter int STATE_WIDTH   = 64,
   parameter int UNROLL        = 8,
   parameter int WARMUP_CYCLES = 16,
   localparam int NUM_QUADRATIC = num_quad(NUM_SHARES)
) (
   input  logic                               in_clock,
   input  logic                               in_reset,
   input  logic [31:0]                        in_seed,
   input  logic                               in_seed_valid,
   output logic                               out_seed_ready,
   input  logic                               in_reseed,
   input  logic                               in_ready,
   output logic                               out_valid,
   output logic [NUM_QUADRATIC*BIT_WIDTH-1:0] out_r,
   output logic [NUM_QUADRATIC*BIT_WIDTH-1:0] out_p
);

   localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

   if (STATE_WIDTH != 64) begin : g_bad_state_width
      $error("masked_randomness_source: STATE_WIDTH must be 64");
   end
   if (UNROLL < 1) begin : g_bad_unroll
      $error("masked_randomness_source: UNROLL must be at least 1");
   end
   if (2 * NUM_QUADRATIC * BIT_WIDTH > STATE_WIDTH) begin : g_bad_output_width
      $error("masked_randomness_source: R and P vectors do not fit in the LFSR state");
   end

   rand_src_state_t         fsm_q;
   logic                    word_cnt_q;
   logic [WCW-1:0]          warm_cnt_q;
   logic                    valid_q;
   logic                    seed_rdy_q;
   logic [STATE_WIDTH-1:0]  state_q;
   logic [STATE_WIDTH-1:0]  state_d;
   logic [STATE_WIDTH-1:0]  state_adv;
   logic [STATE_WIDTH-1:0]  seed_word;

   galois_lfsr_step #(
      .WIDTH (STATE_WIDTH),
      .TAPS  (LFSR_TAPS_64),
      .STEPS (UNROLL)
   ) u_step (
      .state_i (state_q),
      .state_o (state_adv)
   );

   // Incoming seed word shifts in from the bottom; older material moves up
   assign seed_word = {state_q[STATE_WIDTH-33:0], in_seed};

   // LFSR next state: load seed words, advance in WARMUP/RUN, hold on reseed
   always_comb begin
      state_d = state_q;
      if (!in_reseed) begin
         case (fsm_q)
            SEED: begin
               if (in_seed_valid) begin
                  // An all-zero completed seed would lock the LFSR, so substitute 1
                  if (word_cnt_q && (seed_word == '0)) begin
                     state_d = STATE_WIDTH'(1);
                  end else begin
                     state_d = seed_word;
                  end
               end
            end
            WARMUP:  state_d = state_adv;
            RUN:     if (in_ready) state_d = state_adv;
            default: state_d = state_q;
         endcase
      end
   end

   // State register for the LFSR
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencing FSM with registered valid/ready flags; reseed overrides everything
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         fsm_q      <= SEED;
         word_cnt_q <= 1'b0;
         warm_cnt_q <= '0;
         valid_q    <= 1'b0;
         seed_rdy_q <= 1'b1;
      end else if (in_reseed) begin
         fsm_q      <= SEED;
         word_cnt_q <= 1'b0;
         warm_cnt_q <= '0;
         valid_q    <= 1'b0;
         seed_rdy_q <= 1'b1;
      end else begin
         case (fsm_q)
            SEED: begin
               if (in_seed_valid) begin
                  if (word_cnt_q) begin
                     word_cnt_q <= 1'b0;
                     warm_cnt_q <= '0;
                     seed_rdy_q <= 1'b0;
                     if (WARMUP_CYCLES == 0) begin
                        fsm_q   <= RUN;
                        valid_q <= 1'b1;
                     end else begin
                        fsm_q   <= WARMUP;
                     end
                  end else begin
                     word_cnt_q <= 1'b1;
                  end
               end
            end
            WARMUP: begin
               if (warm_cnt_q == WCW'(WARMUP_CYCLES - 1)) begin
                  fsm_q      <= RUN;
                  warm_cnt_q <= '0;
                  valid_q    <= 1'b1;
               end else begin
                  warm_cnt_q <= warm_cnt_q + 1'b1;
               end
            end
            RUN: begin
               valid_q <= 1'b1;
            end
            default: begin
               fsm_q      <= SEED;
               valid_q    <= 1'b0;
               seed_rdy_q <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid      = valid_q;
   assign out_seed_ready = seed_rdy_q;

   // Slice R and P straight from the state; blank them outside RUN so seed material stays internal
   always_comb begin
      out_r = '0;
      out_p = '0;
      if (fsm_q == RUN) begin
         for (int k = 0; k < NUM_QUADRATIC; k++) begin
            out_r[k*BIT_WIDTH +: BIT_WIDTH] = state_q[k*BIT_WIDTH +: BIT_WIDTH];
            out_p[k*BIT_WIDTH +: BIT_WIDTH] = state_q[(NUM_QUADRATIC+k)*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_masked_randomness_source.sv
// Directed bench for masked_randomness_source: seeding, zero-seed guard, warmup length, reseed and async reset.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: in_ready is driven directly by the directed steps.
module tb_masked_randomness_source;

   logic clk;

   // Instance A: UNROLL=1, no warmup
   logic        a_rst, a_seed_vld, a_seed_rdy, a_reseed, a_ready, a_valid;
   logic [31:0] a_seed;
   logic [1:0]  a_r, a_p;

   // Instance B: UNROLL=8, 16 warmup advances
   logic        b_rst, b_seed_vld, b_seed_rdy, b_reseed, b_ready, b_valid;
   logic [31:0] b_seed;
   logic [1:0]  b_r, b_p;

   int checks = 0;
   int errors = 0;

   masked_randomness_source #(
      .NUM_SHARES(2), .BIT_WIDTH(2), .STATE_WIDTH(64), .UNROLL(1), .WARMUP_CYCLES(0)
   ) u_a (
      .in_clock(clk), .in_reset(a_rst), .in_seed(a_seed), .in_seed_valid(a_seed_vld),
      .out_seed_ready(a_seed_rdy), .in_reseed(a_reseed), .in_ready(a_ready),
      .out_valid(a_valid), .out_r(a_r), .out_p(a_p)
   );

   masked_randomness_source #(
      .NUM_SHARES(2), .BIT_WIDTH(2), .STATE_WIDTH(64), .UNROLL(8), .WARMUP_CYCLES(16)
   ) u_b (
      .in_clock(clk), .in_reset(b_rst), .in_seed(b_seed), .in_seed_valid(b_seed_vld),
      .out_seed_ready(b_seed_rdy), .in_reseed(b_reseed), .in_ready(b_ready),
      .out_valid(b_valid), .out_r(b_r), .out_p(b_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rst = 1'b1; a_seed = '0; a_seed_vld = 1'b0; a_reseed = 1'b0; a_ready = 1'b0;
      b_rst = 1'b1; b_seed = '0; b_seed_vld = 1'b0; b_reseed = 1'b0; b_ready = 1'b0;
      #3;
      chk("reset_valid",  64'(a_valid),    64'd0);
      chk("reset_rdy",    64'(a_seed_rdy), 64'd1);
      chk("reset_r",      64'(a_r),        64'd0);
      chk("reset_p",      64'(a_p),        64'd0);
      chk("reset_state",  u_a.state_q,     64'd0);
      @(negedge clk);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Seed 0x00000000 then 0x0000000B, in_ready held low
      a_seed = 32'h0000_0000; a_seed_vld = 1'b1;
      tick();
      chk("t1_w1_valid", 64'(a_valid),    64'd0);
      chk("t1_w1_rdy",   64'(a_seed_rdy), 64'd1);
      a_seed = 32'h0000_000B;
      tick();
      a_seed_vld = 1'b0;
      chk("t1_valid",    64'(a_valid),    64'd1);
      chk("t1_rdy",      64'(a_seed_rdy), 64'd0);
      chk("t1_r",        64'(a_r),        64'd3);
      chk("t1_p",        64'(a_p),        64'd2);
      tick(); tick(); tick();
      chk("t1_hold_r",   64'(a_r),        64'd3);
      chk("t1_hold_p",   64'(a_p),        64'd2);
      chk("t1_hold_st",  u_a.state_q,     64'h0000_0000_0000_000B);

      // One advance with UNROLL=1
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      chk("t2_state",    u_a.state_q,     64'hD800_0000_0000_0005);
      chk("t2_r",        64'(a_r),        64'd1);
      chk("t2_p",        64'(a_p),        64'd1);
      tick();
      chk("t2_hold_st",  u_a.state_q,     64'hD800_0000_0000_0005);

      // Reseed together with in_ready and a seed word: reseed wins, word dropped
      a_reseed = 1'b1; a_ready = 1'b1; a_seed = 32'h1234_5678; a_seed_vld = 1'b1;
      tick();
      a_reseed = 1'b0; a_ready = 1'b0; a_seed_vld = 1'b0;
      chk("t5_valid",    64'(a_valid),    64'd0);
      chk("t5_rdy",      64'(a_seed_rdy), 64'd1);
      chk("t5_state",    u_a.state_q,     64'hD800_0000_0000_0005);
      chk("t5_r",        64'(a_r),        64'd0);
      chk("t5_p",        64'(a_p),        64'd0);

      // All-zero seed is replaced by 1 and the LFSR keeps moving
      a_seed = 32'h0000_0000; a_seed_vld = 1'b1;
      tick();
      chk("t3_w1_valid", 64'(a_valid),    64'd0);
      chk("t3_w1_state", u_a.state_q,     64'h0000_0005_0000_0000);
      tick();
      a_seed_vld = 1'b0;
      chk("t3_valid",    64'(a_valid),    64'd1);
      chk("t3_state",    u_a.state_q,     64'h0000_0000_0000_0001);
      chk("t3_r",        64'(a_r),        64'd1);
      chk("t3_p",        64'(a_p),        64'd0);
      a_ready = 1'b1;
      tick();
      chk("t3_adv1",     u_a.state_q,     64'hD800_0000_0000_0000);
      chk("t3_adv1_r",   64'(a_r),        64'd0);
      chk("t3_adv1_p",   64'(a_p),        64'd0);
      tick();
      a_ready = 1'b0;
      chk("t3_adv2",     u_a.state_q,     64'h6C00_0000_0000_0000);

      // Warmup: out_valid rises exactly 16 edges after the last seed word
      b_seed = 32'h0000_0001; b_seed_vld = 1'b1;
      tick();
      b_seed = 32'h0000_0002;
      tick();
      b_seed_vld = 1'b0;
      chk("t4_state",    u_b.state_q,     64'h0000_0001_0000_0002);
      chk("t4_rdy",      64'(b_seed_rdy), 64'd0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("t4_valid", 64'(b_valid), (i == 16) ? 64'd1 : 64'd0);
         if (i < 16) begin
            chk("t4_r0", 64'(b_r), 64'd0);
            chk("t4_p0", 64'(b_p), 64'd0);
         end
      end

      // Restart seeding, then reset asynchronously in the middle of warmup
      b_reseed = 1'b1;
      tick();
      b_reseed = 1'b0;
      b_seed = 32'h0000_0005; b_seed_vld = 1'b1;
      tick();
      b_seed = 32'h0000_0006;
      tick();
      b_seed_vld = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      chk("t6_pre_rdy",  64'(b_seed_rdy), 64'd0);
      chk("t6_pre_val",  64'(b_valid),    64'd0);
      #2;
      b_rst = 1'b1;
      #1;
      chk("t6_valid",    64'(b_valid),    64'd0);
      chk("t6_rdy",      64'(b_seed_rdy), 64'd1);
      chk("t6_r",        64'(b_r),        64'd0);
      chk("t6_p",        64'(b_p),        64'd0);
      chk("t6_state",    u_b.state_q,     64'd0);
      @(negedge clk);
      b_rst = 1'b0;
      b_seed = 32'hAAAA_0000; b_seed_vld = 1'b1;
      tick();
      chk("t6_w1_rdy",   64'(b_seed_rdy), 64'd1);
      b_seed = 32'h0000_0003;
      tick();
      b_seed_vld = 1'b0;
      chk("t6_w2_state", u_b.state_q,     64'hAAAA_0000_0000_0003);
      chk("t6_w2_rdy",   64'(b_seed_rdy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
